// File: rtl/dbg_mailbox_pkg.sv
// Shared constants for the dbg_mailbox peek/poke mailbox: default sizes and
// the bit layout of each channel's 4-bit visor status nibble.
package dbg_mailbox_pkg;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_SEL_W    = 2;

  localparam int unsigned VS_FIELDS = 4;
  localparam int unsigned PEEK_FULL = 0;
  localparam int unsigned POKE_FULL = 1;
  localparam int unsigned POKE_OVF  = 2;
  localparam int unsigned PEEK_OVF  = 3;

endpackage

// File: rtl/dbg_mailbox_chan.sv
// One peek/poke channel pair: both data registers, full and sticky overflow
// flags, and same-edge arbitration between a fill and a drain.
module dbg_mailbox_chan
  import dbg_mailbox_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             rd,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             fetch,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] peek,
  output logic [WIDTH-1:0] poke,
  output logic             peek_full,
  output logic             poke_full,
  output logic             peek_ovf,
  output logic             poke_ovf
);

  logic peek_take, peek_drop, poke_take, poke_drop;

  // A drain on the same edge frees the slot, so a fill into a full slot is accepted.
  always_comb begin
    peek_take = load & (~peek_full | rd);
    peek_drop = load & peek_full & ~rd;
    poke_take = wr & (~poke_full | fetch);
    poke_drop = wr & poke_full & ~fetch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peek      <= '0;
      poke      <= '0;
      peek_full <= 1'b0;
      poke_full <= 1'b0;
      peek_ovf  <= 1'b0;
      poke_ovf  <= 1'b0;
    end else begin
      if (peek_take) peek <= load_data;
      if (peek_take)  peek_full <= 1'b1;
      else if (rd)    peek_full <= 1'b0;
      if (peek_drop)    peek_ovf <= 1'b1;
      else if (clr_ovf) peek_ovf <= 1'b0;

      if (poke_take) poke <= wr_data;
      if (poke_take)  poke_full <= 1'b1;
      else if (fetch) poke_full <= 1'b0;
      if (poke_drop)    poke_ovf <= 1'b1;
      else if (clr_ovf) poke_ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/dbg_mailbox.sv
// Multi-channel peek/poke mailbox between the target and the visor.
// Optional DBG_MAILBOX_IRQ_EN adds a masked, registered peek-full interrupt.
module dbg_mailbox
  import dbg_mailbox_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned SEL_W    = DEF_SEL_W
) (
  input  logic                      sysclk,
  input  logic                      sysreset,
  input  logic [CHANNELS-1:0]       tg_load,
  input  logic [WIDTH-1:0]          tg_load_data,
  input  logic [CHANNELS-1:0]       tg_read,
  output logic [CHANNELS*WIDTH-1:0] tg_poke_data,
  output logic [CHANNELS*2-1:0]     tg_status,
  input  logic [SEL_W-1:0]          vs_sel,
  input  logic                      vs_rd,
  input  logic                      vs_wr,
  input  logic [WIDTH-1:0]          vs_wr_data,
  output logic [WIDTH-1:0]          vs_rd_data,
  output logic                      vs_rd_valid,
  output logic [CHANNELS*4-1:0]     vs_status,
  input  logic                      vs_clr_ovf
`ifdef DBG_MAILBOX_IRQ_EN
  ,
  input  logic [CHANNELS-1:0]       vs_irq_mask,
  output logic                      vs_irq
`endif
);

  logic [CHANNELS-1:0] hit, peek_full, poke_full, peek_ovf, poke_ovf;
  logic [WIDTH-1:0]    peek [CHANNELS];
  logic [WIDTH-1:0]    rd_mux;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign hit[i] = (vs_sel == SEL_W'(i));

    dbg_mailbox_chan #(.WIDTH(WIDTH)) u_chan (
      .clk       (sysclk),
      .rst       (sysreset),
      .load      (tg_load[i]),
      .load_data (tg_load_data),
      .rd        (vs_rd & hit[i]),
      .wr        (vs_wr & hit[i]),
      .wr_data   (vs_wr_data),
      .fetch     (tg_read[i]),
      .clr_ovf   (vs_clr_ovf),
      .peek      (peek[i]),
      .poke      (tg_poke_data[i*WIDTH +: WIDTH]),
      .peek_full (peek_full[i]),
      .poke_full (poke_full[i]),
      .peek_ovf  (peek_ovf[i]),
      .poke_ovf  (poke_ovf[i])
    );

    assign tg_status[i*2 +: 2] = {poke_full[i], peek_full[i]};
    assign vs_status[i*VS_FIELDS + PEEK_FULL] = peek_full[i];
    assign vs_status[i*VS_FIELDS + POKE_FULL] = poke_full[i];
    assign vs_status[i*VS_FIELDS + POKE_OVF]  = poke_ovf[i];
    assign vs_status[i*VS_FIELDS + PEEK_OVF]  = peek_ovf[i];
  end

  // Out-of-range selects match no channel, so the mux yields zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      if (hit[c]) rd_mux = peek[c];
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      vs_rd_data  <= '0;
      vs_rd_valid <= 1'b0;
    end else begin
      vs_rd_valid <= vs_rd;
      if (vs_rd) vs_rd_data <= rd_mux;
    end
  end

`ifdef DBG_MAILBOX_IRQ_EN
  always_ff @(posedge sysclk) begin
    if (sysreset) vs_irq <= 1'b0;
    else          vs_irq <= |(peek_full & ~vs_irq_mask);
  end
`endif

endmodule

// File: tb/tb_dbg_mailbox.sv
// Randomised and directed bench for dbg_mailbox against a behavioural
// mailbox model; covers the DBG_MAILBOX_IRQ_EN build when that macro is set.
module tb_dbg_mailbox;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [CH-1:0]   ld, rdt;
  logic [W-1:0]    ldd, wrd;
  logic [SW-1:0]   sel;
  logic            vrd, vwr, clr;
  logic [CH*W-1:0] tg_poke_data;
  logic [CH*2-1:0] tg_status;
  logic [W-1:0]    vs_rd_data;
  logic            vs_rd_valid;
  logic [CH*4-1:0] vs_status;
`ifdef DBG_MAILBOX_IRQ_EN
  logic [CH-1:0]   mask;
  logic            vs_irq;
  bit              m_irq;
`endif

  dbg_mailbox #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .sysclk       (clk),
    .sysreset     (rst),
    .tg_load      (ld),
    .tg_load_data (ldd),
    .tg_read      (rdt),
    .tg_poke_data (tg_poke_data),
    .tg_status    (tg_status),
    .vs_sel       (sel),
    .vs_rd        (vrd),
    .vs_wr        (vwr),
    .vs_wr_data   (wrd),
    .vs_rd_data   (vs_rd_data),
    .vs_rd_valid  (vs_rd_valid),
    .vs_status    (vs_status),
    .vs_clr_ovf   (clr)
`ifdef DBG_MAILBOX_IRQ_EN
    ,
    .vs_irq_mask  (mask),
    .vs_irq       (vs_irq)
`endif
  );

  // Behavioural mailbox state
  logic [W-1:0] m_peek [CH];
  logic [W-1:0] m_poke [CH];
  bit           m_pf [CH], m_kf [CH], m_po [CH], m_ko [CH];
  logic [W-1:0] m_rdd;
  bit           m_rdv;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; ld = '0; rdt = '0; ldd = '0; wrd = '0;
    sel = '0; vrd = 1'b0; vwr = 1'b0; clr = 1'b0;
  endtask

  // Advance one clock: predict from the rules, then compare every output.
  task automatic cyc();
    logic [W-1:0] np [CH], nk [CH];
    bit npf [CH], nkf [CH], npo [CH], nko [CH];
    logic [W-1:0] nrdd;
    bit nrdv, nirq;
    logic [CH*W-1:0] e_poke;
    logic [CH*2-1:0] e_tgs;
    logic [CH*4-1:0] e_vs;
    nirq = 1'b0;
`ifdef DBG_MAILBOX_IRQ_EN
    for (int i = 0; i < CH; i++) if (m_pf[i] && !mask[i]) nirq = 1'b1;
`endif
    nrdd = m_rdd;
    nrdv = vrd;
    if (vrd) nrdd = (int'(sel) < CH) ? m_peek[sel] : '0;
    for (int i = 0; i < CH; i++) begin
      bit r, wv, ev_p, ev_k;
      r  = vrd && (int'(sel) == i);
      wv = vwr && (int'(sel) == i);
      np[i] = m_peek[i]; npf[i] = m_pf[i];
      nk[i] = m_poke[i]; nkf[i] = m_kf[i];
      ev_p = 1'b0; ev_k = 1'b0;
      if (ld[i]) begin
        if (!m_pf[i] || r) begin np[i] = ldd; npf[i] = 1'b1; end
        else ev_p = 1'b1;
      end else if (r) npf[i] = 1'b0;
      if (wv) begin
        if (!m_kf[i] || rdt[i]) begin nk[i] = wrd; nkf[i] = 1'b1; end
        else ev_k = 1'b1;
      end else if (rdt[i]) nkf[i] = 1'b0;
      npo[i] = ev_p ? 1'b1 : (clr ? 1'b0 : m_po[i]);
      nko[i] = ev_k ? 1'b1 : (clr ? 1'b0 : m_ko[i]);
    end
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        np[i] = '0; nk[i] = '0; npf[i] = 0; nkf[i] = 0; npo[i] = 0; nko[i] = 0;
      end
      nrdd = '0; nrdv = 1'b0; nirq = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      m_peek[i] = np[i]; m_poke[i] = nk[i];
      m_pf[i] = npf[i]; m_kf[i] = nkf[i]; m_po[i] = npo[i]; m_ko[i] = nko[i];
      e_poke[i*W +: W] = nk[i];
      e_tgs[i*2 +: 2]  = {nkf[i], npf[i]};
      e_vs[i*4 +: 4]   = {npo[i], nko[i], nkf[i], npf[i]};
    end
    m_rdd = nrdd; m_rdv = nrdv;
    chk("poke_data", 64'(tg_poke_data), 64'(e_poke));
    chk("tg_status", 64'(tg_status), 64'(e_tgs));
    chk("vs_status", 64'(vs_status), 64'(e_vs));
    chk("rd_valid", 64'(vs_rd_valid), 64'(m_rdv));
    if (m_rdv) chk("rd_data", 64'(vs_rd_data), 64'(m_rdd));
`ifdef DBG_MAILBOX_IRQ_EN
    m_irq = nirq;
    chk("irq", 64'(vs_irq), 64'(m_irq));
`endif
  endtask

  logic [CH*4-1:0] snap;

  initial begin
    idle();
`ifdef DBG_MAILBOX_IRQ_EN
    mask = '0;
`endif
    for (int i = 0; i < CH; i++) begin
      m_peek[i] = '0; m_poke[i] = '0; m_pf[i] = 0; m_kf[i] = 0; m_po[i] = 0; m_ko[i] = 0;
    end
    m_rdd = '0; m_rdv = 0;
    #1;
    rst = 1'b1; cyc(); cyc();
    chk("lit_reset_status", 64'(vs_status), 64'h0);
    chk("lit_reset_rd", 64'({vs_rd_valid, vs_rd_data}), 64'h0);
    idle();

    ld = 4'b0001; ldd = 16'hA5A5; cyc(); idle();
    chk("lit_peek_full0", 64'(vs_status[0]), 64'h1);
    vrd = 1'b1; sel = 3'd0; cyc(); idle();
    chk("lit_rd_a5a5", 64'({vs_rd_valid, vs_rd_data}), 64'h1A5A5);
    chk("lit_peek_clr0", 64'(vs_status[0]), 64'h0);
    cyc();
    chk("lit_valid_pulse", 64'(vs_rd_valid), 64'h0);

    ld = 4'b0010; ldd = 16'h1111; cyc();
    ldd = 16'h2222; cyc(); idle();
    chk("lit_peek_ovf1", 64'(vs_status[7]), 64'h1);
    vrd = 1'b1; sel = 3'd1; cyc(); idle();
    chk("lit_rd_1111", 64'(vs_rd_data), 64'h1111);
    clr = 1'b1; cyc(); idle();
    chk("lit_ovf1_clr", 64'(vs_status[7]), 64'h0);

    ld = 4'b0100; ldd = 16'h3333; cyc();
    ldd = 16'h4444; vrd = 1'b1; sel = 3'd2; cyc(); idle();
    chk("lit_rd_3333", 64'(vs_rd_data), 64'h3333);
    chk("lit_ch2_full_noovf", 64'(vs_status[11:8]), 64'h1);
    vrd = 1'b1; sel = 3'd2; cyc();
    vrd = 1'b1; sel = 3'd0; cyc(); idle();
    chk("lit_rd_back2back", 64'({vs_rd_valid, vs_rd_data}), 64'h1A5A5);

    vwr = 1'b1; sel = 3'd3; wrd = 16'hBEEF; cyc();
    chk("lit_poke_beef", 64'(tg_poke_data[63:48]), 64'hBEEF);
    chk("lit_poke_full3", 64'(vs_status[13]), 64'h1);
    wrd = 16'h0000; cyc(); idle();
    chk("lit_poke_ovf3", 64'({vs_status[14], tg_poke_data[63:48]}), 64'h1BEEF);
    rdt = 4'b1000; cyc(); idle();
    chk("lit_poke_drain3", 64'(tg_status[7]), 64'h0);

    ld = 4'b0001; ldd = 16'h5A5A; cyc(); idle();
    snap = vs_status;
    vrd = 1'b1; sel = 3'd4; cyc(); idle();
    chk("lit_rd_oob", 64'({vs_rd_valid, vs_rd_data}), 64'h10000);
    chk("lit_oob_flags", 64'(vs_status), 64'(snap));
    ld = 4'b1111; ldd = 16'h7777; vwr = 1'b1; sel = 3'd1; rst = 1'b1; cyc(); idle();
    chk("lit_midreset", 64'({vs_status, tg_status}), 64'h0);
    chk("lit_midreset_data", 64'(tg_poke_data), 64'h0);

`ifdef DBG_MAILBOX_IRQ_EN
    mask = 4'b1110;
    ld = 4'b0010; ldd = 16'h0001; cyc(); idle(); cyc();
    chk("lit_irq_masked", 64'(vs_irq), 64'h0);
    ld = 4'b0001; cyc(); idle();
    chk("lit_irq_lag", 64'(vs_irq), 64'h0);
    cyc();
    chk("lit_irq_set", 64'(vs_irq), 64'h1);
    vrd = 1'b1; sel = 3'd0; cyc(); idle(); cyc();
    chk("lit_irq_drop", 64'(vs_irq), 64'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      ld  = ($urandom_range(0, 2) == 0) ? CH'($urandom) : '0;
      rdt = ($urandom_range(0, 2) == 0) ? CH'($urandom) : '0;
      ldd = W'($urandom);
      wrd = W'($urandom);
      sel = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(4, 7)) : SW'($urandom_range(0, 3));
      vrd = ($urandom_range(0, 2) == 0);
      vwr = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 249) == 0);
`ifdef DBG_MAILBOX_IRQ_EN
      if ($urandom_range(0, 49) == 0) mask = CH'($urandom);
`endif
      cyc();
    end
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_mailbox.md
Name: dbg_mailbox

Overview:
Parametrised multi-channel peek/poke mailbox between a synapse316 target and the visor debugging supervisor. It generalises the single top-of-register-file peek register to CHANNELS bidirectional channels, each with full flags, sticky overflow and a handshake on both sides. The target sees each channel as a register-file slot. The visor reaches all channels through one addressed port with registered read data.

Parameters:
WIDTH, 16, data width of every channel register
CHANNELS, 4, number of peek/poke channel pairs (1..16)
SEL_W, 2, width of visor channel select; must be at least clog2(CHANNELS)

Ports:
sysclk  in  1  single clock
sysreset  in  1  synchronous, active-high reset
tg_load  in  CHANNELS  target write strobe, one bit per peek channel
tg_load_data  in  WIDTH  target write data, shared by all channels
tg_read  in  CHANNELS  target read strobe, one bit per poke channel
tg_poke_data  out  CHANNELS*WIDTH  poke registers, flat; channel i at [i*WIDTH +: WIDTH]
tg_status  out  CHANNELS*2  {poke_full, peek_full}, visible to target
vs_sel  in  SEL_W  visor channel select
vs_rd  in  1  visor peek-read strobe
vs_wr  in  1  visor poke-write strobe
vs_wr_data  in  WIDTH  visor poke data
vs_rd_data  out  WIDTH  registered peek data
vs_rd_valid  out  1  one-cycle pulse, the cycle after vs_rd
vs_status  out  CHANNELS*4  {peek_ovf, poke_ovf, poke_full, peek_full}
vs_clr_ovf  in  1  clears all sticky overflow flags

Behaviour:
- Reset: all peek/poke registers 0, all full and ovf flags 0, vs_rd_data 0, vs_rd_valid 0. Reset overrides every strobe in the same cycle.
- Peek path (target to visor):
  - tg_load[i] while peek_full[i]=0 captures data and sets peek_full[i] at the next edge.
  - tg_load[i] while peek_full[i]=1 drops the data, keeps the old value and sets peek_ovf[i].
  - Several tg_load bits in one cycle each write tg_load_data to their own channel.
- Visor read:
  - vs_rd in cycle N gives vs_rd_data = peek[vs_sel] and vs_rd_valid=1 in cycle N+1.
  - It also clears peek_full[vs_sel] at that edge.
  - Reading an empty channel returns the stale value, with no error flag.
  - vs_sel >= CHANNELS returns 0 and changes no flags.
- Simultaneous tg_load[i] and vs_rd on channel i while full:
  - The read returns the old data.
  - The new data is captured and peek_full stays 1. No overflow, because the slot is freed in the same edge.
  - If the channel was empty, the new data is captured, full is set, and the read returns the old stale value.
- Poke path (visor to target), mirror image:
  - vs_wr when poke_full[vs_sel]=0 captures the data and sets full.
  - vs_wr when full drops the data and sets poke_ovf.
  - tg_read[i] clears poke_full[i] at the next edge. tg_poke_data is combinational from the registers, so the read has zero latency.
  - Simultaneous vs_wr and tg_read on the same channel: the target reads the old value, the new value is captured, and full stays 1.
- vs_clr_ovf clears all ovf bits. An overflow event in the same cycle wins, and its bit stays set.
- vs_rd and vs_wr in the same cycle are both honoured, on the same vs_sel.
- vs_rd_valid is a single-cycle pulse. Back-to-back reads give consecutive pulses.

Optional Feature:
DBG_MAILBOX_IRQ_EN:
- Defined: adds input vs_irq_mask[CHANNELS-1:0] and output vs_irq.
  - vs_irq is registered and equals OR over i of (peek_full[i] & ~vs_irq_mask[i]).
  - It asserts one cycle after the full flag sets and drops one cycle after it clears.
  - It resets to 0.
- Undefined: neither port exists and the visor must poll vs_status.

Decomposition:
- Shared package/header:
  - status field offsets: PEEK_FULL=0, POKE_FULL=1, POKE_OVF=2, PEEK_OVF=3 in each 4-bit channel nibble
  - default WIDTH/CHANNELS constants
- One natural sub-module, dbg_mailbox_chan: one channel pair holding both registers, full/ovf flags and same-cycle arbitration, instantiated CHANNELS times by a generate loop.
- The top level holds the vs_sel decode, the read mux/register and the IRQ logic.

Test Plan:
- Reset, then tg_load[0] with 16'hA5A5 -> peek_full[0]=1; vs_rd sel=0 -> next cycle vs_rd_data=A5A5, vs_rd_valid=1, peek_full[0]=0.
- Two tg_load[1] writes (1111, then 2222) with no read -> peek_ovf[1]=1; read returns 1111; vs_clr_ovf -> ovf=0.
- Channel 2 full with 3333; same cycle tg_load[2]=4444 and vs_rd sel=2 -> rd_data=3333, full stays 1, no ovf; next read returns 4444.
- vs_wr sel=3 data BEEF -> poke_full[3]=1 and tg_poke_data[63:48]=BEEF; second vs_wr 0000 -> poke_ovf[3]=1, data still BEEF; tg_read[3] -> full=0.
- vs_rd with sel=CHANNELS (when CHANNELS < 2^SEL_W) -> rd_data=0, valid=1, no flag changes; sysreset asserted mid-sequence -> all flags and data 0 at the next edge.
- IRQ_EN build with mask=4'b1110: tg_load[1] -> vs_irq stays 0; tg_load[0] -> vs_irq=1 one cycle after full; read channel 0 -> vs_irq=0.
